// File: rtl/mem_byte_seq_if.sv
// Request/response bus between the core's MEM stage and the byte-serialising
// load/store initiator. Signal suffixes are seen from the initiator's side.
interface mem_byte_seq_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        resp_valid_o;
  logic [31:0] resp_rdata_o;

  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    output req_ready_o, resp_valid_o, resp_rdata_o
  );

  modport master (
    output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o
  );
endinterface

// File: rtl/mem_byte_seq.sv
// Serialises byte/half/word loads and stores into little-endian byte beats on
// an 8-bit RAM with combinational read, then returns extended load data.
module mem_byte_seq #(
  parameter int ADDR_W = 13
) (
  input  logic              clk_i,
  input  logic              rst_i,
  mem_byte_seq_if.slave     bus,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_wren_o,
  output logic [7:0]        ram_wdata_o,
  input  logic [7:0]        ram_rdata_i
);

  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, RESP = 2'd2} state_t;

  state_t            r_state;
  logic              r_we;
  logic              r_uns;
  logic [1:0]        r_last;
  logic [1:0]        r_beat;
  logic [31:0]       r_wdata;
  logic [31:0]       r_asm;
  logic [31:0]       r_rdata;
  logic [ADDR_W-1:0] r_ram_addr;

  logic [31:0]       w_asm_next;
  logic [7:0]        w_wbyte;

  // Fill the bytes above the last loaded one with the sign or with zero.
  function automatic logic [31:0] f_extend(input logic [31:0] raw,
                                           input logic [1:0]  last,
                                           input logic        uns);
    logic signed [7:0]  s8;
    logic signed [15:0] s16;
    logic signed [31:0] ext;
    s8  = raw[7:0];
    s16 = raw[15:0];
    ext = '0;
    f_extend = raw;
    case (last)
      2'd0: begin
        ext = s8;
        f_extend = uns ? {24'd0, raw[7:0]} : ext;
      end
      2'd1: begin
        ext = s16;
        f_extend = uns ? {16'd0, raw[15:0]} : ext;
      end
      default: f_extend = raw;
    endcase
  endfunction

  always_comb begin
    w_asm_next = r_asm;
    w_asm_next[{r_beat, 3'b000} +: 8] = ram_rdata_i;
  end

  assign w_wbyte          = r_wdata[{r_beat, 3'b000} +: 8];
  assign bus.req_ready_o  = (r_state == IDLE);
  assign bus.resp_valid_o = (r_state == RESP);
  assign bus.resp_rdata_o = r_rdata;
  assign ram_addr_o       = r_ram_addr;
  assign ram_wren_o       = (r_state == XFER) && r_we;
  assign ram_wdata_o      = ram_wren_o ? w_wbyte : 8'd0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_beat     <= 2'd0;
      r_rdata    <= 32'd0;
      r_ram_addr <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.req_valid_i) begin
            r_we       <= bus.req_we_i;
            r_uns      <= bus.req_unsigned_i;
            r_last     <= (bus.req_size_i == 2'd0) ? 2'd0 :
                          (bus.req_size_i == 2'd1) ? 2'd1 : 2'd3;
            r_ram_addr <= bus.req_addr_i[ADDR_W-1:0];
            r_wdata    <= bus.req_wdata_i;
            r_asm      <= 32'd0;
            r_beat     <= 2'd0;
            r_state    <= XFER;
          end
        end
        XFER: begin
          r_asm <= w_asm_next;
          // Address stays on the final beat so it holds once the transfer ends.
          if (r_beat == r_last) begin
            r_state <= RESP;
            r_rdata <= r_we ? 32'd0 : f_extend(w_asm_next, r_last, r_uns);
          end else begin
            r_beat     <= r_beat + 2'd1;
            r_ram_addr <= r_ram_addr + 1'b1;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_byte_seq.sv
// Bench for mem_byte_seq: directed scenarios plus random traffic checked
// against a byte-array memory model with arithmetic load/extend rules.
module tb_mem_byte_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] ram_addr;
  logic        ram_wren;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic        init_req;

  logic [7:0]  ram      [0:8191];
  logic [7:0]  init_img [0:8191];
  logic [7:0]  ref_mem  [0:8191];
  logic [12:0] wq_addr[$];
  logic [7:0]  wq_data[$];
  logic        resp_after;
  int          n_checks = 0;
  int          n_fail = 0;

  mem_byte_seq_if bus();

  mem_byte_seq #(.ADDR_W(13)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .bus        (bus),
    .ram_addr_o (ram_addr),
    .ram_wren_o (ram_wren),
    .ram_wdata_o(ram_wdata),
    .ram_rdata_i(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 8192; i++) ram[i] <= init_img[i];
    end else if (ram_wren) begin
      ram[ram_addr] <= ram_wdata;
    end
  end
  assign ram_rdata = ram[ram_addr];

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [1:0] sz,
                                           input logic uns);
    int n;
    longint v;
    int unsigned a;
    n = nbytes(sz);
    v = 0;
    for (int k = 0; k < n; k++) begin
      a = (addr + k) % 8192;
      v += longint'(ref_mem[a]) << (8 * k);
    end
    if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    return 32'(v);
  endfunction

  task automatic ref_store(input logic [31:0] addr, input logic [1:0] sz, input logic [31:0] wd);
    int unsigned a;
    for (int k = 0; k < nbytes(sz); k++) begin
      a = (addr + k) % 8192;
      ref_mem[a] = 8'((wd >> (8 * k)) & 32'hFF);
    end
  endtask

  // Issues one request starting on a negedge; returns data, cycles from the
  // acceptance cycle to the response cycle, and logs every write beat seen.
  task automatic do_op(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output int lat);
    int guard;
    wq_addr.delete();
    wq_data.delete();
    bus.req_valid_i    = 1'b1;
    bus.req_we_i       = we;
    bus.req_size_i     = sz;
    bus.req_unsigned_i = uns;
    bus.req_addr_i     = addr;
    bus.req_wdata_i    = wd;
    guard = 0;
    while (!bus.req_ready_o && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!bus.req_ready_o) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: ready=%0b want 1", bus.req_ready_o);
    end
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = $urandom;
    bus.req_wdata_i = $urandom;
    lat = 1;
    while (!bus.resp_valid_o && lat < 12) begin
      if (ram_wren) begin
        wq_addr.push_back(ram_addr);
        wq_data.push_back(ram_wdata);
      end
      @(negedge clk);
      lat++;
    end
    rd = bus.resp_rdata_o;
    @(negedge clk);
    resp_after = bus.resp_valid_o;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.req_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %0b want 1", bus.req_ready_o); end
    n_checks++; if (bus.resp_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %0b want 0", bus.resp_valid_o); end
    n_checks++; if (bus.resp_rdata_o !== 32'd0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", bus.resp_rdata_o); end
    n_checks++; if (ram_addr !== 13'd0) begin n_fail++; $display("FAIL rst_ram_addr: got %h want 0", ram_addr); end
    n_checks++; if (ram_wren !== 1'b0) begin n_fail++; $display("FAIL rst_wren: got %0b want 0", ram_wren); end
    n_checks++; if (ram_wdata !== 8'd0) begin n_fail++; $display("FAIL rst_wdata: got %h want 0", ram_wdata); end
    rst = 1'b0;
  endtask

  task automatic test_word_store_load;
    logic [31:0] rd;
    logic [31:0] wd;
    int lat;
    wd = 32'hA1B2C3D4;
    do_op(1'b1, 2'd2, 1'b0, 32'h10, wd, rd, lat);
    ref_store(32'h10, 2'd2, wd);
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL sw_latency: got %0d want 5", lat); end
    n_checks++; if (wq_addr.size() !== 4) begin n_fail++; $display("FAIL sw_beats: got %0d want 4", wq_addr.size()); end
    else for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (wq_addr[k] !== 13'(32'h10 + k) || wq_data[k] !== 8'(wd >> (8 * k))) begin
        n_fail++;
        $display("FAIL sw_beat%0d: got %h@%h want %h@%h", k, wq_data[k], wq_addr[k], 8'(wd >> (8 * k)), 13'(32'h10 + k));
      end
    end
    n_checks++; if (rd !== 32'd0) begin n_fail++; $display("FAIL sw_rdata: got %h want 0", rd); end
    n_checks++; if (resp_after !== 1'b0) begin n_fail++; $display("FAIL sw_resp_width: got %0b want 0", resp_after); end
    n_checks++; if (ram_addr !== 13'h13) begin n_fail++; $display("FAIL sw_addr_hold: got %h want 13", ram_addr); end
    do_op(1'b0, 2'd2, 1'b0, 32'h10, 32'd0, rd, lat);
    n_checks++; if (rd !== 32'hA1B2C3D4) begin n_fail++; $display("FAIL lw_data: got %h want a1b2c3d4", rd); end
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL lw_latency: got %0d want 5", lat); end
    n_checks++; if (wq_addr.size() !== 0) begin n_fail++; $display("FAIL lw_wren: got %0d writes want 0", wq_addr.size()); end
  endtask

  task automatic test_byte_sign;
    logic [31:0] rd;
    int lat;
    do_op(1'b1, 2'd0, 1'b0, 32'h20, 32'h12345680, rd, lat);
    ref_store(32'h20, 2'd0, 32'h12345680);
    n_checks++; if (wq_addr.size() !== 1 || ram[13'h20] !== 8'h80) begin n_fail++; $display("FAIL sb_write: got %h writes=%0d want 80 writes=1", ram[13'h20], wq_addr.size()); end
    do_op(1'b0, 2'd0, 1'b0, 32'h20, 32'd0, rd, lat);
    n_checks++; if (rd !== 32'hFFFFFF80) begin n_fail++; $display("FAIL lb_data: got %h want ffffff80", rd); end
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL lb_latency: got %0d want 2", lat); end
    do_op(1'b0, 2'd0, 1'b1, 32'h20, 32'd0, rd, lat);
    n_checks++; if (rd !== 32'h00000080) begin n_fail++; $display("FAIL lbu_data: got %h want 00000080", rd); end
  endtask

  task automatic test_half;
    logic [31:0] rd;
    int lat;
    do_op(1'b1, 2'd1, 1'b0, 32'h31, 32'h00008001, rd, lat);
    ref_store(32'h31, 2'd1, 32'h00008001);
    n_checks++;
    if (wq_addr.size() !== 2 || wq_addr[0] !== 13'h31 || wq_data[0] !== 8'h01 ||
        wq_addr[1] !== 13'h32 || wq_data[1] !== 8'h80) begin
      n_fail++;
      $display("FAIL sh_beats: got %0d writes, first %h@%h want 01@31 80@32", wq_addr.size(), wq_data[0], wq_addr[0]);
    end
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL sh_latency: got %0d want 3", lat); end
    do_op(1'b0, 2'd1, 1'b0, 32'h31, 32'd0, rd, lat);
    n_checks++; if (rd !== 32'hFFFF8001) begin n_fail++; $display("FAIL lh_data: got %h want ffff8001", rd); end
    do_op(1'b0, 2'd1, 1'b1, 32'h31, 32'd0, rd, lat);
    n_checks++; if (rd !== 32'h00008001) begin n_fail++; $display("FAIL lhu_data: got %h want 00008001", rd); end
    repeat (2) @(negedge clk);
    n_checks++; if (bus.resp_rdata_o !== 32'h00008001) begin n_fail++; $display("FAIL rdata_hold: got %h want 00008001", bus.resp_rdata_o); end
  endtask

  task automatic test_wrap;
    logic [31:0] rd;
    int lat;
    logic [12:0] exp_a [4];
    exp_a = '{13'h1FFE, 13'h1FFF, 13'h0000, 13'h0001};
    do_op(1'b1, 2'd2, 1'b0, 32'h1FFE, 32'h11223344, rd, lat);
    ref_store(32'h1FFE, 2'd2, 32'h11223344);
    n_checks++; if (wq_addr.size() !== 4) begin n_fail++; $display("FAIL wrap_beats: got %0d want 4", wq_addr.size()); end
    else for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (wq_addr[k] !== exp_a[k] || wq_data[k] !== 8'(32'h11223344 >> (8 * k))) begin
        n_fail++;
        $display("FAIL wrap_beat%0d: got %h@%h want %h@%h", k, wq_data[k], wq_addr[k], 8'(32'h11223344 >> (8 * k)), exp_a[k]);
      end
    end
    do_op(1'b0, 2'd2, 1'b0, 32'hFFFF_1FFE, 32'd0, rd, lat);
    n_checks++; if (rd !== 32'h11223344) begin n_fail++; $display("FAIL wrap_lw: got %h want 11223344", rd); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] exp;
    logic [31:0] rd;
    int lowcnt;
    int seen_wr;
    int resp_cnt;
    exp = ref_load(32'h100, 2'd2, 1'b0);
    rd = 32'd0;
    bus.req_valid_i = 1'b1; bus.req_we_i = 1'b0; bus.req_size_i = 2'd2;
    bus.req_unsigned_i = 1'b0; bus.req_addr_i = 32'h100; bus.req_wdata_i = 32'd0;
    @(negedge clk);
    lowcnt = 0; seen_wr = 0; resp_cnt = 0;
    while (!bus.req_ready_o && lowcnt < 12) begin
      bus.req_we_i    = 1'b1;
      bus.req_size_i  = 2'($urandom);
      bus.req_addr_i  = $urandom;
      bus.req_wdata_i = $urandom;
      if (ram_wren) seen_wr++;
      if (bus.resp_valid_o) begin rd = bus.resp_rdata_o; resp_cnt++; end
      lowcnt++;
      @(negedge clk);
    end
    n_checks++; if (lowcnt !== 5) begin n_fail++; $display("FAIL b2b_busy_cycles: got %0d want 5", lowcnt); end
    n_checks++; if (seen_wr !== 0) begin n_fail++; $display("FAIL b2b_stray_writes: got %0d want 0", seen_wr); end
    n_checks++; if (resp_cnt !== 1 || rd !== exp) begin n_fail++; $display("FAIL b2b_load: got %h x%0d want %h x1", rd, resp_cnt, exp); end
    bus.req_we_i = 1'b1; bus.req_size_i = 2'd0; bus.req_addr_i = 32'h200; bus.req_wdata_i = 32'h5A;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    n_checks++; if (ram_wren !== 1'b1 || ram_addr !== 13'h200) begin n_fail++; $display("FAIL b2b_next_accept: got wren=%0b addr=%h want 1 200", ram_wren, ram_addr); end
    @(negedge clk);
    n_checks++; if (bus.resp_valid_o !== 1'b1) begin n_fail++; $display("FAIL b2b_next_resp: got %0b want 1", bus.resp_valid_o); end
    ref_store(32'h200, 2'd0, 32'h5A);
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd;
    int lat;
    int stray;
    do_op(1'b1, 2'd2, 1'b0, 32'h40, 32'h0, rd, lat);
    ref_store(32'h40, 2'd2, 32'h0);
    do_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, rd, lat);
    bus.req_valid_i = 1'b1; bus.req_we_i = 1'b1; bus.req_size_i = 2'd2;
    bus.req_addr_i = 32'h40; bus.req_wdata_i = 32'hDEADBEEF;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (ram_wren !== 1'b0) begin n_fail++; $display("FAIL rmid_wren: got %0b want 0", ram_wren); end
    n_checks++; if (bus.resp_rdata_o !== 32'd0 || ram_addr !== 13'd0 || ram_wdata !== 8'd0) begin
      n_fail++; $display("FAIL rmid_outputs: rdata=%h addr=%h wdata=%h want 0 0 0", bus.resp_rdata_o, ram_addr, ram_wdata); end
    rst = 1'b0;
    n_checks++; if (bus.req_ready_o !== 1'b1) begin n_fail++; $display("FAIL rmid_ready: got %0b want 1", bus.req_ready_o); end
    stray = 0;
    repeat (5) begin
      if (bus.resp_valid_o || ram_wren) stray++;
      @(negedge clk);
    end
    n_checks++; if (stray !== 0) begin n_fail++; $display("FAIL rmid_stray: got %0d events want 0", stray); end
    n_checks++;
    if (ram[13'h40] !== 8'hEF || ram[13'h41] !== 8'hBE || ram[13'h42] !== ref_mem[13'h42] || ram[13'h43] !== ref_mem[13'h43]) begin
      n_fail++; $display("FAIL rmid_ram: got %h %h %h %h want ef be %h %h", ram[13'h40], ram[13'h41], ram[13'h42], ram[13'h43], ref_mem[13'h42], ref_mem[13'h43]);
    end
    ref_mem[13'h40] = 8'hEF;
    ref_mem[13'h41] = 8'hBE;
  endtask

  task automatic test_reset_with_req;
    int stray;
    rst = 1'b1;
    bus.req_valid_i = 1'b1; bus.req_we_i = 1'b1; bus.req_size_i = 2'd2;
    bus.req_addr_i = 32'h50; bus.req_wdata_i = 32'hCAFEF00D;
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid_i = 1'b0;
    stray = 0;
    repeat (6) begin
      if (bus.resp_valid_o || ram_wren || !bus.req_ready_o) stray++;
      @(negedge clk);
    end
    n_checks++; if (stray !== 0) begin n_fail++; $display("FAIL rst_wins: got %0d busy/write cycles want 0", stray); end
  endtask

  task automatic test_random;
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [31:0] exp;
    int lat;
    int mism;
    for (int i = 0; i < 80; i++) begin
      we = 1'($urandom); sz = 2'($urandom); uns = 1'($urandom);
      addr = (i % 4 == 0) ? 32'h1FFC + 32'($urandom_range(0, 3)) : $urandom;
      wd = $urandom;
      exp = we ? 32'd0 : ref_load(addr, sz, uns);
      do_op(we, sz, uns, addr, wd, rd, lat);
      if (we) ref_store(addr, sz, wd);
      n_checks++;
      if (rd !== exp || lat !== nbytes(sz) + 1 || wq_addr.size() !== (we ? nbytes(sz) : 0) || resp_after !== 1'b0) begin
        n_fail++;
        $display("FAIL rand%0d: we=%0b sz=%0d a=%h got %h lat=%0d wr=%0d want %h lat=%0d", i, we, sz, addr, rd, lat, wq_addr.size(), exp, nbytes(sz) + 1);
      end
    end
    mism = 0;
    for (int i = 0; i < 8192; i++) if (ram[i] !== ref_mem[i]) mism++;
    n_checks++; if (mism !== 0) begin n_fail++; $display("FAIL ram_image: got %0d differing bytes want 0", mism); end
  endtask

  initial begin
    rst = 1'b1;
    init_req = 1'b1;
    bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_size_i = 2'd0;
    bus.req_unsigned_i = 1'b0; bus.req_addr_i = 32'd0; bus.req_wdata_i = 32'd0;
    for (int i = 0; i < 8192; i++) begin
      init_img[i] = 8'($urandom);
      ref_mem[i]  = init_img[i];
    end
    @(negedge clk);
    init_req = 1'b0;
    test_reset();
    test_word_store_load();
    test_byte_sign();
    test_half();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_reset_with_req();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
